// File: rtl/spi_regfile_periph.sv
// SPI peripheral exposing a bank of NUM_REGS control registers.
// All SPI pins are synchronised into clk; frames are R/W bit, address, data (MSB first).
module spi_regfile_periph #(
    parameter int SYNC_FLOPS = 2,
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 8,
    parameter int NUM_REGS   = 5,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         SCLK,
    input  logic                         COPI,
    input  logic                         nCS,
    output logic                         CIPO,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err,
    output logic                         busy
);

    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W);
    localparam logic SCLK_IDLE = (CPOL != 0);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_ADDR, S_DATA} state_t;

    logic [SYNC_FLOPS:0]   sclk_q, sclk_d, ncs_q, ncs_d, vld_q, vld_d;
    logic [SYNC_FLOPS-1:0] copi_q, copi_d;
    logic                  armed_q, armed_d;
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_LEN-1:0]  shift_q, shift_d, shift_nx;
    logic [DATA_W-1:0]     rd_q, rd_d;
    logic                  rw_q, rw_d;
    logic                  dsmp_q, dsmp_d;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic                  wr_strobe_q, wr_strobe_d;
    logic                  frame_err_q, frame_err_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;

    logic sclk_s, sclk_p, ncs_s, ncs_p, copi_s;
    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample, launch;
    logic ncs_fall, ncs_rise;
    logic [ADDR_W-1:0] wr_a, rd_a;
    logic [DATA_W-1:0] wr_data, rd_val;
    logic              wr_hit;

    always_comb begin
        sclk_d = {sclk_q[SYNC_FLOPS-1:0], SCLK};
        ncs_d  = {ncs_q[SYNC_FLOPS-1:0], nCS};
        copi_d = {copi_q[SYNC_FLOPS-2:0], COPI};
        vld_d  = {vld_q[SYNC_FLOPS-1:0], 1'b1};
    end

    assign sclk_s = sclk_q[SYNC_FLOPS-1];
    assign sclk_p = sclk_q[SYNC_FLOPS];
    assign ncs_s  = ncs_q[SYNC_FLOPS-1];
    assign ncs_p  = ncs_q[SYNC_FLOPS];
    assign copi_s = copi_q[SYNC_FLOPS-1];

    assign sclk_rise  = sclk_s & ~sclk_p;
    assign sclk_fall  = ~sclk_s & sclk_p;
    assign lead_edge  = (CPOL != 0) ? sclk_fall : sclk_rise;
    assign trail_edge = (CPOL != 0) ? sclk_rise : sclk_fall;
    assign sample     = (CPHA != 0) ? trail_edge : lead_edge;
    assign launch     = (CPHA != 0) ? lead_edge : trail_edge;
    // A start only counts once nCS has been seen high from real pin samples,
    // so a frame still in flight across reset release is ignored.
    assign ncs_fall   = armed_q & ncs_p & ~ncs_s;
    assign ncs_rise   = ncs_s & ~ncs_p;

    assign shift_nx = {shift_q[FRAME_LEN-2:0], copi_s};
    assign wr_a     = shift_q[DATA_W +: ADDR_W];
    assign wr_data  = shift_q[DATA_W-1:0];
    assign rd_a     = shift_nx[ADDR_W-1:0];

    always_comb begin
        wr_hit = 1'b0;
        rd_val = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (wr_a == ADDR_W'(k)) wr_hit = 1'b1;
            if (rd_a == ADDR_W'(k)) rd_val = regs_q[k];
        end
    end

    always_comb begin
        armed_d     = armed_q | (vld_q[SYNC_FLOPS] & ncs_s & ncs_p);
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rd_d        = rd_q;
        rw_d        = rw_q;
        dsmp_d      = dsmp_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        frame_err_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        if (state_q == S_IDLE) begin
            if (ncs_fall) begin
                state_d = S_CMD;
                cnt_d   = '0;
                shift_d = '0;
                rd_d    = '0;
                rw_d    = 1'b0;
                dsmp_d  = 1'b0;
            end
        end else if (ncs_rise) begin
            state_d = S_IDLE;
            rd_d    = '0;
            dsmp_d  = 1'b0;
            if (cnt_q != CNT_FULL) begin
                frame_err_d = 1'b1;
            end else if (shift_q[FRAME_LEN-1] && wr_hit) begin
                for (int k = 0; k < NUM_REGS; k++)
                    if (wr_a == ADDR_W'(k)) regs_d[k] = wr_data;
                wr_strobe_d = 1'b1;
                wr_addr_d   = wr_a;
            end
        end else if (sample) begin
            shift_d = shift_nx;
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
            case (state_q)
                S_CMD:  state_d = S_ADDR;
                S_ADDR: if (cnt_q == CNT_ADDR) begin
                    state_d = S_DATA;
                    rw_d    = shift_nx[ADDR_W];
                    if (!shift_nx[ADDR_W]) rd_d = rd_val;
                end
                S_DATA: dsmp_d = 1'b1;
                default: ;
            endcase
        end else if (launch && dsmp_q) begin
            // Advance only after the controller has sampled the current bit.
            rd_d   = rd_q << 1;
            dsmp_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q      <= {(SYNC_FLOPS+1){SCLK_IDLE}};
            ncs_q       <= '1;
            copi_q      <= '0;
            vld_q       <= '0;
            armed_q     <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            rd_q        <= '0;
            rw_q        <= 1'b0;
            dsmp_q      <= 1'b0;
            regs_q      <= '0;
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            sclk_q      <= sclk_d;
            ncs_q       <= ncs_d;
            copi_q      <= copi_d;
            vld_q       <= vld_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rd_q        <= rd_d;
            rw_q        <= rw_d;
            dsmp_q      <= dsmp_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            frame_err_q <= frame_err_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    assign CIPO      = (state_q == S_DATA) && !rw_q && rd_q[DATA_W-1];
    assign cipo_oe   = ~ncs_s;
    assign busy      = (state_q != S_IDLE);
    assign regs_out  = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign frame_err = frame_err_q;
    assign wr_addr   = wr_addr_q;

endmodule
